// File: rtl/rat_ckpt_bundle.sv
// Superscalar register alias table with intra-bundle bypass and a circular
// stack of checkpoints that can be taken, restored and released.
module rat_ckpt_bundle #(
  parameter int P_ADDR_WIDTH = 7,
  parameter int L_ADDR_WIDTH = 5,
  parameter int C_NUM        = 4,
  parameter int INSTR_COUNT  = 2,
  parameter int SRC_COUNT    = 2
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic [INSTR_COUNT-1:0]                                  write_en,
  input  logic [INSTR_COUNT-1:0][L_ADDR_WIDTH-1:0]                write_addr,
  input  logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0]                write_data,
  input  logic [INSTR_COUNT-1:0][SRC_COUNT-1:0][L_ADDR_WIDTH-1:0] read_addr,
  output logic [INSTR_COUNT-1:0][SRC_COUNT-1:0][P_ADDR_WIDTH-1:0] read_data,
  output logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0]                old_data,
  input  logic                                                    take_checkpoint,
  input  logic [$clog2(INSTR_COUNT)-1:0]                          ckpt_instr,
  output logic                                                    ckpt_accept,
  output logic [$clog2(C_NUM)-1:0]                                ckpt_id,
  input  logic                                                    restore_checkpoint,
  input  logic [$clog2(C_NUM)-1:0]                                restore_id,
  input  logic                                                    release_checkpoint,
  output logic [$clog2(C_NUM):0]                                  ckpt_count,
  output logic                                                    ckpt_full,
  output logic                                                    ckpt_empty
);

  localparam int NUM_L = 2 ** L_ADDR_WIDTH;
  localparam int CW    = $clog2(C_NUM);
  localparam int NW    = CW + 1;
  localparam int IW    = $clog2(INSTR_COUNT);

  typedef logic [NUM_L-1:0][P_ADDR_WIDTH-1:0] rat_t;

  rat_t            cur_rat_q, cur_rat_d, snap_d;
  rat_t            ckpt_mem_q [C_NUM];
  logic [CW-1:0]   head_q, head_d, tail_q, tail_d, tail_rel, restore_off;
  logic [NW-1:0]   count_q, count_d, count_rel;
  logic            release_eff, accept;

  // Rename lookup: a later enabled writer earlier in the bundle overrides the table.
  always_comb begin
    for (int i = 0; i < INSTR_COUNT; i++) begin
      for (int s = 0; s < SRC_COUNT; s++) begin
        read_data[i][s] = cur_rat_q[read_addr[i][s]];
        for (int j = 0; j < INSTR_COUNT; j++) begin
          if (j < i && write_en[j] && write_addr[j] == read_addr[i][s])
            read_data[i][s] = write_data[j];
        end
      end
      old_data[i] = cur_rat_q[write_addr[i]];
      for (int j = 0; j < INSTR_COUNT; j++) begin
        if (j < i && write_en[j] && write_addr[j] == write_addr[i])
          old_data[i] = write_data[j];
      end
    end
  end

  assign ckpt_full   = (count_q == NW'(C_NUM));
  assign ckpt_empty  = (count_q == '0);
  assign ckpt_count  = count_q;
  assign ckpt_id     = head_q;
  assign release_eff = release_checkpoint && !ckpt_empty;
  assign accept      = take_checkpoint && !restore_checkpoint &&
                       (!ckpt_full || release_checkpoint);
  assign ckpt_accept = accept;
  assign tail_rel    = tail_q + CW'(release_eff);
  assign restore_off = restore_id - tail_rel;
  assign count_rel   = count_q - NW'(release_eff);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    snap_d = cur_rat_q;
    for (int i = 0; i < INSTR_COUNT; i++) begin
      if (IW'(i) <= ckpt_instr && write_en[i])
        snap_d[write_addr[i]] = write_data[i];
    end
  end

  // Restore overrides the whole bundle; release still retires the tail first.
  always_comb begin
    cur_rat_d = cur_rat_q;
    head_d    = head_q;
    tail_d    = tail_rel;
    count_d   = count_q;
    if (restore_checkpoint) begin
      cur_rat_d = ckpt_mem_q[restore_id];
      head_d    = restore_id + CW'(1);
      count_d   = {1'b0, restore_off} + NW'(1);
    end else begin
      for (int i = 0; i < INSTR_COUNT; i++) begin
        if (write_en[i])
          cur_rat_d[write_addr[i]] = write_data[i];
      end
      if (accept)
        head_d = head_q + CW'(1);
      count_d = count_q + NW'(accept) - NW'(release_eff);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_L; r++)
        cur_rat_q[r] <= P_ADDR_WIDTH'(r);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      cur_rat_q <= cur_rat_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // NOTE: checkpoint storage has no reset; slots are only read once written and live.
  always_ff @(posedge clk) begin
    if (accept)
      ckpt_mem_q[head_q] <= snap_d;
  end

  a_restore_live : assert property (@(posedge clk) disable iff (!rst_n)
    restore_checkpoint |-> ({1'b0, restore_off} < count_rel));

  a_release_not_restored : assert property (@(posedge clk) disable iff (!rst_n)
    (restore_checkpoint && release_eff) |-> (restore_id != tail_q));

endmodule

// File: tb/tb_rat_ckpt_bundle.sv
// Bench for rat_ckpt_bundle: constant rename table, directed checkpoint
// sequences and random traffic against a queue-based reference model.
module tb_rat_ckpt_bundle;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           write_en;
  logic [1:0][4:0]      write_addr;
  logic [1:0][6:0]      write_data;
  logic [1:0][1:0][4:0] read_addr;
  logic [1:0][1:0][6:0] read_data;
  logic [1:0][6:0]      old_data;
  logic                 take_checkpoint;
  logic [0:0]           ckpt_instr;
  logic                 ckpt_accept;
  logic [1:0]           ckpt_id;
  logic                 restore_checkpoint;
  logic [1:0]           restore_id;
  logic                 release_checkpoint;
  logic [2:0]           ckpt_count;
  logic                 ckpt_full;
  logic                 ckpt_empty;

  rat_ckpt_bundle #(
    .P_ADDR_WIDTH(7), .L_ADDR_WIDTH(5), .C_NUM(4), .INSTR_COUNT(2), .SRC_COUNT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_addr(read_addr), .read_data(read_data), .old_data(old_data),
    .take_checkpoint(take_checkpoint), .ckpt_instr(ckpt_instr),
    .ckpt_accept(ckpt_accept), .ckpt_id(ckpt_id),
    .restore_checkpoint(restore_checkpoint), .restore_id(restore_id),
    .release_checkpoint(release_checkpoint), .ckpt_count(ckpt_count),
    .ckpt_full(ckpt_full), .ckpt_empty(ckpt_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: mapping table, checkpoint images, live slots oldest-first.
  int m_rat [32];
  int m_ck  [4][32];
  int m_live [$];
  int m_head;

  typedef struct {
    logic [1:0]      en;
    logic [1:0][4:0] wa;
    logic [1:0][6:0] wd;
    logic [3:0][4:0] ra;
    logic [3:0][6:0] rd;
    logic [1:0][6:0] od;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_fwd(int i, int a);
    for (int j = i - 1; j >= 0; j--)
      if (write_en[j] && int'(write_addr[j]) == a) return int'(write_data[j]);
    return m_rat[a];
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) m_rat[r] = r;
    m_live.delete();
    m_head = 0;
  endtask

  task automatic idle();
    write_en = '0; write_addr = '0; write_data = '0; read_addr = '0;
    take_checkpoint = 1'b0; ckpt_instr = '0;
    restore_checkpoint = 1'b0; restore_id = '0; release_checkpoint = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  // Compare every output with the model, advance the model, then take the edge.
  task automatic step();
    int  sz, k;
    bit  acc;
    int  snap [32];
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 2; s++)
        check($sformatf("read_data[%0d][%0d]", i, s), 32'(read_data[i][s]),
              m_fwd(i, int'(read_addr[i][s])));
      check($sformatf("old_data[%0d]", i), 32'(old_data[i]), m_fwd(i, int'(write_addr[i])));
    end
    sz  = m_live.size();
    acc = take_checkpoint && !restore_checkpoint && (sz < 4 || release_checkpoint);
    check("ckpt_accept", 32'(ckpt_accept), 32'(acc));
    if (acc) check("ckpt_id", 32'(ckpt_id), m_head);
    check("ckpt_count", 32'(ckpt_count), sz);
    check("ckpt_full", 32'(ckpt_full), 32'(sz == 4));
    check("ckpt_empty", 32'(ckpt_empty), 32'(sz == 0));
    if (restore_checkpoint) begin
      if (release_checkpoint && sz > 0) void'(m_live.pop_front());
      k = 0;
      for (int q = 0; q < m_live.size(); q++)
        if (m_live[q] == int'(restore_id)) k = q;
      m_live = m_live[0:k];
      for (int r = 0; r < 32; r++) m_rat[r] = m_ck[restore_id][r];
      m_head = (int'(restore_id) + 1) % 4;
    end else begin
      if (acc) begin
        for (int r = 0; r < 32; r++) snap[r] = m_rat[r];
        for (int i = 0; i <= int'(ckpt_instr); i++)
          if (write_en[i]) snap[write_addr[i]] = int'(write_data[i]);
        for (int r = 0; r < 32; r++) m_ck[m_head][r] = snap[r];
      end
      if (release_checkpoint && sz > 0) void'(m_live.pop_front());
      if (acc) begin
        m_live.push_back(m_head);
        m_head = (m_head + 1) % 4;
      end
      for (int i = 0; i < 2; i++)
        if (write_en[i]) m_rat[write_addr[i]] = int'(write_data[i]);
    end
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(logic [1:0] en, int wa0, int wd0, int wa1, int wd1,
                              int r00, int r01, int r10, int r11,
                              int e00, int e01, int e10, int e11, int o0, int o1);
    vec_t v;
    v.en = en;
    v.wa[0] = 5'(wa0); v.wa[1] = 5'(wa1);
    v.wd[0] = 7'(wd0); v.wd[1] = 7'(wd1);
    v.ra[0] = 5'(r00); v.ra[1] = 5'(r01); v.ra[2] = 5'(r10); v.ra[3] = 5'(r11);
    v.rd[0] = 7'(e00); v.rd[1] = 7'(e01); v.rd[2] = 7'(e10); v.rd[3] = 7'(e11);
    v.od[0] = 7'(o0);  v.od[1] = 7'(o1);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sz, base;
    // Rows chain: each row's writes commit before the next row is applied.
    tbl[0] = mk(2'b00, 0, 0,  0, 0,   5, 0, 5, 31,    5, 0,  5, 31,   0,  0);
    tbl[1] = mk(2'b11, 3, 40, 9, 60,  3, 9, 3, 9,     3, 9,  40, 9,   3,  9);
    tbl[2] = mk(2'b11, 7, 40, 7, 41,  3, 9, 7, 3,     40, 60, 40, 40, 7,  40);
    tbl[3] = mk(2'b00, 3, 0,  3, 0,   7, 31, 7, 9,    41, 31, 41, 60, 40, 40);
    tbl[4] = mk(2'b01, 9, 10, 9, 11,  9, 0, 9, 7,     60, 0,  10, 41, 60, 10);
    tbl[5] = mk(2'b10, 9, 99, 9, 12,  9, 3, 9, 1,     10, 40, 10, 1,  10, 10);
    tbl[6] = mk(2'b00, 0, 0,  1, 0,   9, 7, 3, 1,     12, 41, 40, 1,  0,  1);

    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    check("reset_count", 32'(ckpt_count), 0);
    check("reset_empty", 32'(ckpt_empty), 1);
    check("reset_full", 32'(ckpt_full), 0);

    for (int n = 0; n < 7; n++) begin
      idle();
      write_en = tbl[n].en; write_addr = tbl[n].wa; write_data = tbl[n].wd;
      for (int k = 0; k < 4; k++) read_addr[k / 2][k % 2] = tbl[n].ra[k];
      #1;
      for (int k = 0; k < 4; k++)
        check($sformatf("tbl%0d_rd%0d", n, k), 32'(read_data[k / 2][k % 2]), 32'(tbl[n].rd[k]));
      check($sformatf("tbl%0d_old0", n), 32'(old_data[0]), 32'(tbl[n].od[0]));
      check($sformatf("tbl%0d_old1", n), 32'(old_data[1]), 32'(tbl[n].od[1]));
      step();
    end

    // Reset asserted between edges while a bundle is presented.
    idle();
    write_en = 2'b01; write_addr[0] = 5'd5; write_data[0] = 7'd77;
    read_addr[0][0] = 5'd9; read_addr[1][0] = 5'd5;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_i0_r9", 32'(read_data[0][0]), 9);
    check("midrst_i1_fwd", 32'(read_data[1][0]), 77);
    check("midrst_count", 32'(ckpt_count), 0);
    @(posedge clk); #1;
    read_addr[0][0] = 5'd5;
    #1;
    check("midrst_r5_held", 32'(read_data[0][0]), 5);
    idle();
    rst_n = 1'b1;
    m_reset();
    @(posedge clk); #1;

    // Checkpoint at instr 0 excludes instr 1's write; restore rolls back later writes.
    write_en = 2'b11; write_addr[0] = 5'd1; write_data[0] = 7'd50;
    write_addr[1] = 5'd2; write_data[1] = 7'd51;
    take_checkpoint = 1'b1; ckpt_instr = 1'b0;
    #1;
    check("take0_accept", 32'(ckpt_accept), 1);
    check("take0_id", 32'(ckpt_id), 0);
    step();
    idle();
    write_en = 2'b01; write_addr[0] = 5'd1; write_data[0] = 7'd70;
    step();
    idle();
    restore_checkpoint = 1'b1; restore_id = 2'd0;
    write_en = 2'b10; write_addr[1] = 5'd3; write_data[1] = 7'd90;
    step();
    idle();
    read_addr[0][0] = 5'd1; read_addr[0][1] = 5'd2; read_addr[1][0] = 5'd3;
    #1;
    check("restore_r1", 32'(read_data[0][0]), 50);
    check("restore_r2", 32'(read_data[0][1]), 2);
    check("restore_r3", 32'(read_data[1][0]), 3);
    check("restore_count", 32'(ckpt_count), 1);
    take_checkpoint = 1'b1;
    #1;
    check("restore_head", 32'(ckpt_id), 1);
    step(); step(); step();
    idle();
    #1;
    check("full_flag", 32'(ckpt_full), 1);
    check("full_count", 32'(ckpt_count), 4);
    take_checkpoint = 1'b1;
    #1;
    check("full_reject", 32'(ckpt_accept), 0);
    step();
    take_checkpoint = 1'b1; release_checkpoint = 1'b1;
    #1;
    check("full_take_rel_accept", 32'(ckpt_accept), 1);
    check("full_take_rel_id", 32'(ckpt_id), 0);
    step();
    idle();
    #1;
    check("full_take_rel_count", 32'(ckpt_count), 4);

    // Restore with release at count 3: bundle writes and take are discarded.
    do_reset();
    take_checkpoint = 1'b1;
    step(); step(); step();
    idle();
    restore_checkpoint = 1'b1; restore_id = 2'd1; release_checkpoint = 1'b1;
    take_checkpoint = 1'b1; write_en = 2'b01; write_addr[0] = 5'd4; write_data[0] = 7'd33;
    #1;
    check("rr_take_blocked", 32'(ckpt_accept), 0);
    step();
    idle();
    read_addr[0][0] = 5'd4;
    #1;
    check("rr_write_dropped", 32'(read_data[0][0]), 4);
    check("rr_count", 32'(ckpt_count), 1);
    take_checkpoint = 1'b1;
    #1;
    check("rr_head", 32'(ckpt_id), 2);
    step();
    idle();
    release_checkpoint = 1'b1;
    step();
    idle();
    #1;
    check("rr_after_release", 32'(ckpt_count), 1);

    // Random traffic with only legal restores.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      idle();
      write_en = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        write_addr[i] = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        write_data[i] = 7'($urandom);
        for (int s = 0; s < 2; s++)
          read_addr[i][s] = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      end
      take_checkpoint    = ($urandom % 3 == 0);
      ckpt_instr         = 1'($urandom);
      release_checkpoint = ($urandom % 4 == 0);
      sz   = m_live.size();
      base = (release_checkpoint && sz > 0) ? 1 : 0;
      if ($urandom % 6 == 0 && sz > base) begin
        restore_checkpoint = 1'b1;
        restore_id = 2'(m_live[$urandom_range(base, sz - 1)]);
      end
      step();
      if (n % 150 == 149) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
